// File: rtl/uart_tx_arb.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arb
// Description : Round-robin arbiter and sequencer that shares one uart
//               transmitter's Avalon MM write port among N byte-stream
//               requesters. A grant is held for a whole packet (delimited by
//               req_last), so bytes from different requesters never
//               interleave on the line. If an owner goes idle inside a
//               packet, the lock is released after TMO idle cycles.
// Ports       : clk, rst               - single clock, sync active-high reset
//               req_valid/data/last    - per-requester byte stream inputs
//               req_ready              - per-requester accept strobe (<=1 hot)
//               avalon_*               - write master toward the uart slave
//               grant                  - one-hot current owner, 0 when idle
//               busy                   - arbiter not idle
//               err_tmo                - one-cycle pulse on a lock timeout
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arb #(
   parameter int N   = 4,
   parameter int AAW = 1,
   parameter int ADW = 32,
   parameter int ABW = ADW / 8,
   parameter int TMO = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     req_valid,
   input  logic [8*N-1:0]   req_data,
   input  logic [N-1:0]     req_last,
   output logic [N-1:0]     req_ready,
   output logic             avalon_write,
   output logic [AAW-1:0]   avalon_address,
   output logic [ABW-1:0]   avalon_byteenable,
   output logic [ADW-1:0]   avalon_writedata,
   input  logic             avalon_waitrequest,
   output logic [N-1:0]     grant,
   output logic             busy,
   output logic             err_tmo
);

   localparam int              c_PW       = (N > 1) ? $clog2(N) : 1;
   localparam logic [c_PW:0]   c_NW       = (c_PW + 1)'(N);
   localparam logic [15:0]     c_TMO_LAST = 16'(TMO - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WRITE = 2'd1,
      S_HOLD  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [c_PW-1:0]   ptr_q, ptr_d;
   logic [c_PW-1:0]   owner_q, owner_d;
   logic [7:0]        byte_q, byte_d;
   logic              last_q, last_d;
   logic [15:0]       cnt_q, cnt_d;
   logic [N-1:0]      grant_q, grant_d;
   logic              err_q, err_d;

   logic              w_win_found;
   logic [c_PW-1:0]   w_win_idx;
   logic [c_PW:0]     w_scan;
   logic [c_PW-1:0]   w_sel_idx;
   logic [7:0]        w_sel_byte;
   logic              w_sel_last;
   logic              w_sel_valid;

   // Round-robin scan starting just after the last owner. The sum stays
   // below 2N, so a single conditional subtract performs the modulo even
   // when N is not a power of two.
   always_comb begin
      w_win_found = 1'b0;
      w_win_idx   = '0;
      w_scan      = '0;
      for (int k = 1; k <= N; k++) begin
         w_scan = {1'b0, ptr_q} + (c_PW + 1)'(k);
         if (w_scan >= c_NW) begin
            w_scan = w_scan - c_NW;
         end
         if (!w_win_found && req_valid[w_scan[c_PW-1:0]]) begin
            w_win_found = 1'b1;
            w_win_idx   = w_scan[c_PW-1:0];
         end
      end
   end

   // In HOLD only the locked owner is looked at; in IDLE the scan winner.
   always_comb begin
      w_sel_idx   = (state_q == S_HOLD) ? owner_q : w_win_idx;
      w_sel_byte  = '0;
      w_sel_last  = 1'b0;
      w_sel_valid = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (w_sel_idx == c_PW'(i)) begin
            w_sel_byte  = req_data[8*i +: 8];
            w_sel_last  = req_last[i];
            w_sel_valid = req_valid[i];
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      owner_d   = owner_q;
      byte_d    = byte_q;
      last_d    = last_q;
      cnt_d     = cnt_q;
      grant_d   = grant_q;
      err_d     = 1'b0;
      req_ready = '0;
      // Nothing may be accepted while reset is held.
      if (!rst) begin
         case (state_q)
            S_IDLE: begin
               if (w_win_found) begin
                  req_ready[w_win_idx] = 1'b1;
                  byte_d               = w_sel_byte;
                  last_d               = w_sel_last;
                  owner_d              = w_win_idx;
                  grant_d              = '0;
                  grant_d[w_win_idx]   = 1'b1;
                  state_d              = S_WRITE;
               end
            end
            S_WRITE: begin
               if (!avalon_waitrequest) begin
                  if (last_q) begin
                     state_d = S_IDLE;
                     ptr_d   = owner_q;
                     grant_d = '0;
                  end else begin
                     state_d = S_HOLD;
                     cnt_d   = '0;
                  end
               end
            end
            S_HOLD: begin
               // A byte arriving on the timeout cycle takes precedence.
               if (w_sel_valid) begin
                  req_ready[owner_q] = 1'b1;
                  byte_d             = w_sel_byte;
                  last_d             = w_sel_last;
                  state_d            = S_WRITE;
               end else if (cnt_q == c_TMO_LAST) begin
                  state_d = S_IDLE;
                  ptr_d   = owner_q;
                  grant_d = '0;
                  err_d   = 1'b1;
               end else begin
                  cnt_d = cnt_q + 16'd1;
               end
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         ptr_q   <= c_PW'(N - 1);
         owner_q <= '0;
         byte_q  <= '0;
         last_q  <= 1'b0;
         cnt_q   <= '0;
         grant_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         byte_q  <= byte_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         grant_q <= grant_d;
         err_q   <= err_d;
      end
   end

   assign avalon_write      = (state_q == S_WRITE);
   assign avalon_address    = '0;
   assign avalon_byteenable = '1;
   assign avalon_writedata  = avalon_write ? ADW'(byte_q) : '0;
   assign grant             = grant_q;
   assign busy              = (state_q != S_IDLE);
   assign err_tmo           = err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_arb
// Description : Directed bench for uart_tx_arb (N=4, TMO=4). A vector table
//               covers reset, a single byte and round-robin rotation; hand
//               sequences cover packet lock, back-pressure, lock timeout and
//               reset in the middle of a write.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arb;

   localparam int N   = 4;
   localparam int AAW = 1;
   localparam int ADW = 32;
   localparam int ABW = 4;
   localparam int TMO = 4;

   logic             clk;
   logic             rst;
   logic [N-1:0]     req_valid;
   logic [8*N-1:0]   req_data;
   logic [N-1:0]     req_last;
   logic [N-1:0]     req_ready;
   logic             avalon_write;
   logic [AAW-1:0]   avalon_address;
   logic [ABW-1:0]   avalon_byteenable;
   logic [ADW-1:0]   avalon_writedata;
   logic             avalon_waitrequest;
   logic [N-1:0]     grant;
   logic             busy;
   logic             err_tmo;

   int n_pass  = 0;
   int n_total = 0;
   int xfer_cnt = 0;

   uart_tx_arb #(
      .N   (N),
      .AAW (AAW),
      .ADW (ADW),
      .ABW (ABW),
      .TMO (TMO)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .req_valid          (req_valid),
      .req_data           (req_data),
      .req_last           (req_last),
      .req_ready          (req_ready),
      .avalon_write       (avalon_write),
      .avalon_address     (avalon_address),
      .avalon_byteenable  (avalon_byteenable),
      .avalon_writedata   (avalon_writedata),
      .avalon_waitrequest (avalon_waitrequest),
      .grant              (grant),
      .busy               (busy),
      .err_tmo            (err_tmo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Completed Avalon transfers.
   always @(posedge clk) begin
      if (avalon_write && !avalon_waitrequest) xfer_cnt <= xfer_cnt + 1;
   end

   typedef struct {
      logic [3:0]  v;
      logic [31:0] d;
      logic [3:0]  l;
      logic        wr;
      logic        r;
      logic [3:0]  e_rdy;
      logic        e_wr;
      logic [7:0]  e_byte;
      logic [3:0]  e_gnt;
      logic        e_busy;
      logic        e_err;
   } vec_t;

   vec_t tbl[19];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // One clock cycle: drive inputs on the falling edge, check outputs 1ns
   // later, well clear of the rising edge.
   task automatic cyc(input logic [3:0] v, input logic [31:0] d, input logic [3:0] l,
                      input logic wr, input logic r,
                      input logic [3:0] e_rdy, input logic e_wr, input logic [7:0] e_byte,
                      input logic [3:0] e_gnt, input logic e_busy, input logic e_err,
                      input string tag);
      @(negedge clk);
      req_valid          = v;
      req_data           = d;
      req_last           = l;
      avalon_waitrequest = wr;
      rst                = r;
      #1;
      chk({tag, " ready"}, 32'(req_ready), 32'(e_rdy));
      chk({tag, " write"}, 32'(avalon_write), 32'(e_wr));
      if (e_wr || r) chk({tag, " wdata"}, avalon_writedata, e_wr ? {24'h0, e_byte} : 32'h0);
      chk({tag, " grant"}, 32'(grant), 32'(e_gnt));
      chk({tag, " busy"}, 32'(busy), 32'(e_busy));
      chk({tag, " err_tmo"}, 32'(err_tmo), 32'(e_err));
   endtask

   initial begin
      int xfer0;
      localparam logic [31:0] RR = 32'hA3A2_A1A0;
      localparam logic [31:0] SB = 32'h0041_0000;

      // Reset, requester 2 single byte, reset again, round robin 0,1,2,3,0,1.
      tbl[0]  = '{4'b0000, 32'h0, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0};
      tbl[1]  = '{4'b1111, RR,    4'b1111, 1'b0, 1'b1, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0};
      tbl[2]  = '{4'b0100, SB,    4'b0100, 1'b0, 1'b0, 4'b0100, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0};
      tbl[3]  = '{4'b0000, SB,    4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1, 8'h41, 4'b0100, 1'b1, 1'b0};
      tbl[4]  = '{4'b0000, 32'h0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0};
      tbl[5]  = '{4'b0000, 32'h0, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0};
      tbl[6]  = '{4'b1111, RR,    4'b1111, 1'b0, 1'b0, 4'b0001, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0};
      tbl[7]  = '{4'b1111, RR,    4'b1111, 1'b0, 1'b0, 4'b0000, 1'b1, 8'hA0, 4'b0001, 1'b1, 1'b0};
      tbl[8]  = '{4'b1111, RR,    4'b1111, 1'b0, 1'b0, 4'b0010, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0};
      tbl[9]  = '{4'b1111, RR,    4'b1111, 1'b0, 1'b0, 4'b0000, 1'b1, 8'hA1, 4'b0010, 1'b1, 1'b0};
      tbl[10] = '{4'b1111, RR,    4'b1111, 1'b0, 1'b0, 4'b0100, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0};
      tbl[11] = '{4'b1111, RR,    4'b1111, 1'b0, 1'b0, 4'b0000, 1'b1, 8'hA2, 4'b0100, 1'b1, 1'b0};
      tbl[12] = '{4'b1111, RR,    4'b1111, 1'b0, 1'b0, 4'b1000, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0};
      tbl[13] = '{4'b1111, RR,    4'b1111, 1'b0, 1'b0, 4'b0000, 1'b1, 8'hA3, 4'b1000, 1'b1, 1'b0};
      tbl[14] = '{4'b1111, RR,    4'b1111, 1'b0, 1'b0, 4'b0001, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0};
      tbl[15] = '{4'b1111, RR,    4'b1111, 1'b0, 1'b0, 4'b0000, 1'b1, 8'hA0, 4'b0001, 1'b1, 1'b0};
      tbl[16] = '{4'b1111, RR,    4'b1111, 1'b0, 1'b0, 4'b0010, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0};
      tbl[17] = '{4'b1111, RR,    4'b1111, 1'b0, 1'b0, 4'b0000, 1'b1, 8'hA1, 4'b0010, 1'b1, 1'b0};
      tbl[18] = '{4'b0000, 32'h0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0};

      rst = 1'b1; req_valid = '0; req_data = '0; req_last = '0; avalon_waitrequest = 1'b0;
      repeat (3) @(posedge clk);

      for (int i = 0; i < 19; i++) begin
         cyc(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].wr, tbl[i].r,
             tbl[i].e_rdy, tbl[i].e_wr, tbl[i].e_byte, tbl[i].e_gnt, tbl[i].e_busy, tbl[i].e_err,
             $sformatf("vec%0d", i));
      end
      chk("address", 32'(avalon_address), 32'h0);
      chk("byteenable", 32'(avalon_byteenable), 32'hF);

      // Move the pointer to requester 0 so requester 1 wins the next scan.
      cyc(4'b0001, 32'h0000_00EE, 4'b0001, 1'b0, 1'b0, 4'b0001, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0, "pre c0");
      cyc(4'b0000, 32'h0,         4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1, 8'hEE, 4'b0001, 1'b1, 1'b0, "pre c1");

      // Packet lock: requester 1 sends 10,11,12 while requester 0 waits.
      cyc(4'b0011, 32'h0000_1020, 4'b0001, 1'b0, 1'b0, 4'b0010, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0, "lock c0");
      cyc(4'b0011, 32'h0000_1120, 4'b0001, 1'b0, 1'b0, 4'b0000, 1'b1, 8'h10, 4'b0010, 1'b1, 1'b0, "lock c1");
      cyc(4'b0011, 32'h0000_1120, 4'b0001, 1'b0, 1'b0, 4'b0010, 1'b0, 8'h00, 4'b0010, 1'b1, 1'b0, "lock c2");
      cyc(4'b0011, 32'h0000_1220, 4'b0011, 1'b0, 1'b0, 4'b0000, 1'b1, 8'h11, 4'b0010, 1'b1, 1'b0, "lock c3");
      cyc(4'b0011, 32'h0000_1220, 4'b0011, 1'b0, 1'b0, 4'b0010, 1'b0, 8'h00, 4'b0010, 1'b1, 1'b0, "lock c4");
      cyc(4'b0001, 32'h0000_0020, 4'b0001, 1'b0, 1'b0, 4'b0000, 1'b1, 8'h12, 4'b0010, 1'b1, 1'b0, "lock c5");
      cyc(4'b0001, 32'h0000_0020, 4'b0001, 1'b0, 1'b0, 4'b0001, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0, "lock c6");
      cyc(4'b0000, 32'h0,         4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1, 8'h20, 4'b0001, 1'b1, 1'b0, "lock c7");

      // Back-pressure: 9 stall cycles then completion; one transfer only.
      cyc(4'b0100, 32'h0077_0000, 4'b0100, 1'b0, 1'b0, 4'b0100, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0, "bp c0");
      xfer0 = xfer_cnt;
      for (int i = 0; i < 9; i++) begin
         cyc(4'b0100, 32'h0078_0000, 4'b0100, 1'b1, 1'b0, 4'b0000, 1'b1, 8'h77, 4'b0100, 1'b1, 1'b0,
             $sformatf("bp stall%0d", i));
      end
      cyc(4'b0100, 32'h0078_0000, 4'b0100, 1'b0, 1'b0, 4'b0000, 1'b1, 8'h77, 4'b0100, 1'b1, 1'b0, "bp done");
      cyc(4'b0100, 32'h0078_0000, 4'b0100, 1'b0, 1'b0, 4'b0100, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0, "bp next");
      chk("bp transfers", 32'(xfer_cnt - xfer0), 32'd1);
      cyc(4'b0000, 32'h0,         4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1, 8'h78, 4'b0100, 1'b1, 1'b0, "bp c12");

      // Timeout: requester 3 sends 55 without last then goes quiet.
      cyc(4'b1001, 32'h5500_0030, 4'b0001, 1'b0, 1'b0, 4'b1000, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0, "tmo c0");
      cyc(4'b0001, 32'h0000_0030, 4'b0001, 1'b0, 1'b0, 4'b0000, 1'b1, 8'h55, 4'b1000, 1'b1, 1'b0, "tmo c1");
      for (int i = 0; i < TMO; i++) begin
         cyc(4'b0001, 32'h0000_0030, 4'b0001, 1'b0, 1'b0, 4'b0000, 1'b0, 8'h00, 4'b1000, 1'b1, 1'b0,
             $sformatf("tmo hold%0d", i));
      end
      cyc(4'b0001, 32'h0000_0030, 4'b0001, 1'b0, 1'b0, 4'b0001, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b1, "tmo pulse");
      cyc(4'b0000, 32'h0,         4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1, 8'h30, 4'b0001, 1'b1, 1'b0, "tmo after");

      // Reset held 3 cycles in the middle of a stalled write.
      cyc(4'b0010, 32'h0000_6600, 4'b0010, 1'b1, 1'b0, 4'b0010, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0, "rst c0");
      cyc(4'b0010, 32'h0000_6600, 4'b0010, 1'b1, 1'b1, 4'b0000, 1'b1, 8'h66, 4'b0010, 1'b1, 1'b0, "rst c1");
      cyc(4'b0011, 32'h0000_6699, 4'b0011, 1'b1, 1'b1, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0, "rst c2");
      cyc(4'b0011, 32'h0000_6699, 4'b0011, 1'b1, 1'b1, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0, "rst c3");
      cyc(4'b0011, 32'h0000_6699, 4'b0011, 1'b0, 1'b0, 4'b0001, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0, "rst c4");
      cyc(4'b0000, 32'h0,         4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1, 8'h99, 4'b0001, 1'b1, 1'b0, "rst c5");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
